// File: rtl/pp_pipeline_accel_fifo2axis.sv
// FIFO-read to AXI4-Stream bridge with per-row TLAST, start-of-frame TUSER and
// a 2-entry registered skid buffer so if_read never depends on m_axis_tready.
module pp_pipeline_accel_fifo2axis #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DIM_WIDTH  = 12
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic [DIM_WIDTH-1:0]  rows,
  input  logic [DIM_WIDTH-1:0]  cols,
  input  logic                  if_empty_n,
  input  logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_read,
  output logic                  if_read_ce,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                  state, state_nxt;
  logic [1:0]              rst_sync;
  logic                    rst_n;
  logic [DIM_WIDTH-1:0]    rows_q, cols_q, col_cnt, row_cnt;
  logic [2*DIM_WIDTH-1:0]  rd_rem, frame_px;
  logic                    sof;
  logic [DATA_WIDTH-1:0]   ent0, ent1;
  logic [1:0]              occ;
  logic                    push, beat, col_end, row_end, start_acc;

  // Reset asserts asynchronously, releases two clocks later.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) rst_sync <= '0;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign frame_px  = (2*DIM_WIDTH)'(rows) * (2*DIM_WIDTH)'(cols);
  assign start_acc = (state == IDLE) && ap_start;
  assign col_end   = (cols_q != '0) && (col_cnt == cols_q - DIM_WIDTH'(1));
  assign row_end   = (rows_q != '0) && (row_cnt == rows_q - DIM_WIDTH'(1));
  assign push      = if_read && if_empty_n;
  assign beat      = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge ap_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (ap_start) state_nxt = (frame_px != '0) ? RUN : DONE;
      RUN:     if (push && rd_rem == (2*DIM_WIDTH)'(1)) state_nxt = FLUSH;
      FLUSH:   if (beat && row_end && col_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ap_idle       = (state == IDLE);
    ap_done       = (state == DONE);
    if_read       = (state == RUN) && if_empty_n && (rd_rem != '0) && (occ != 2'd2);
    if_read_ce    = 1'b1;
    m_axis_tvalid = (occ != 2'd0);
    m_axis_tdata  = ent0;
    m_axis_tlast  = m_axis_tvalid && col_end;
    m_axis_tuser  = m_axis_tvalid && sof;
  end

  always_ff @(posedge ap_clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q  <= '0;
      cols_q  <= '0;
      rd_rem  <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
      sof     <= 1'b0;
    end else if (start_acc) begin
      rows_q  <= rows;
      cols_q  <= cols;
      rd_rem  <= frame_px;
      col_cnt <= '0;
      row_cnt <= '0;
      sof     <= 1'b1;
    end else begin
      if (push) rd_rem <= rd_rem - (2*DIM_WIDTH)'(1);
      if (beat) begin
        sof <= 1'b0;
        if (col_end) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + DIM_WIDTH'(1);
        end else begin
          col_cnt <= col_cnt + DIM_WIDTH'(1);
        end
      end
    end
  end

  // ent0 is always the head; push with simultaneous beat only happens at occ==1.
  always_ff @(posedge ap_clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0 <= '0;
      ent1 <= '0;
      occ  <= '0;
    end else begin
      unique case ({push, beat})
        2'b10: begin
          if (occ == 2'd0) ent0 <= if_dout;
          else             ent1 <= if_dout;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        2'b11:   ent0 <= if_dout;
        default: ;
      endcase
    end
  end

endmodule
